led_status_ctrl: RTL and testbench

LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

---
 rtl/led_status_ctrl.sv | 122 ++++++++++++
 tb/tb_led_status_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/led_status_ctrl.sv
// LED status controller: per-channel off / on / shared blink / retriggerable event stretch.
// Optional macro LED_STATUS_SYNC_EN inserts a 2-flop synchroniser on evt before edge detection.
module led_status_ctrl #(
  parameter int NB_LED      = 8,
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BLINK_HZ    = 1,
  parameter int STRETCH_CYC = 5000000
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [2*NB_LED-1:0] mode,
  input  logic [NB_LED-1:0]   evt,
  output logic [NB_LED-1:0]   led,
  output logic                tick
);

  localparam int HALF_PERIOD = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int PW          = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int SW          = $clog2(STRETCH_CYC + 1);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(HALF_PERIOD - 1);
  localparam logic [SW-1:0] STRETCH_LD = SW'(STRETCH_CYC);

  if (HALF_PERIOD < 2) begin : g_bad_half_period
    $error("led_status_ctrl: HALF_PERIOD must be at least 2");
  end
  if (STRETCH_CYC < 1) begin : g_bad_stretch
    $error("led_status_ctrl: STRETCH_CYC must be at least 1");
  end

  // Edges are ignored until the evt pipeline holds real post-reset samples.
`ifdef LED_STATUS_SYNC_EN
  localparam int ARM_LEN = 3;
`else
  localparam int ARM_LEN = 1;
`endif

  logic [PW-1:0]      presc_q, presc_d;
  logic               phase_q, phase_d;
  logic               tick_q, tick_d;
  logic [NB_LED-1:0]  evt_prev_q, evt_prev_d;
  logic [ARM_LEN-1:0] arm_q, arm_d;
  logic [NB_LED-1:0]  led_q, led_d;
  logic [SW-1:0]      cnt_q [NB_LED];
  logic [SW-1:0]      cnt_d [NB_LED];
  logic [NB_LED-1:0]  evt_s;
  logic [NB_LED-1:0]  rise;

`ifdef LED_STATUS_SYNC_EN
  logic [NB_LED-1:0]  sync1_q, sync1_d;
  logic [NB_LED-1:0]  sync2_q, sync2_d;
  assign evt_s = sync2_q;
`else
  assign evt_s = evt;
`endif

  assign rise = {NB_LED{arm_q[ARM_LEN-1]}} & evt_s & ~evt_prev_q;

  always_comb begin
    presc_d    = presc_q + 1'b1;
    phase_d    = phase_q;
    tick_d     = 1'b0;
    evt_prev_d = evt_s;
    arm_d      = ARM_LEN'({arm_q, 1'b1});
`ifdef LED_STATUS_SYNC_EN
    sync1_d    = evt;
    sync2_d    = sync1_q;
`endif
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      phase_d = ~phase_q;
      tick_d  = 1'b1;
    end
    // Stretch counters keep running whatever the mode, so mode 11 shows remaining time.
    for (int i = 0; i < NB_LED; i++) begin
      if (rise[i]) begin
        cnt_d[i] = STRETCH_LD;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end else begin
        cnt_d[i] = '0;
      end
      case (mode[2*i +: 2])
        2'b00:   led_d[i] = 1'b0;
        2'b01:   led_d[i] = 1'b1;
        2'b10:   led_d[i] = phase_d;
        default: led_d[i] = (cnt_d[i] != '0);
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      presc_q    <= '0;
      phase_q    <= 1'b0;
      tick_q     <= 1'b0;
      evt_prev_q <= '0;
      arm_q      <= '0;
      led_q      <= '0;
      for (int i = 0; i < NB_LED; i++) cnt_q[i] <= '0;
`ifdef LED_STATUS_SYNC_EN
      sync1_q    <= '0;
      sync2_q    <= '0;
`endif
    end else begin
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      tick_q     <= tick_d;
      evt_prev_q <= evt_prev_d;
      arm_q      <= arm_d;
      led_q      <= led_d;
      for (int i = 0; i < NB_LED; i++) cnt_q[i] <= cnt_d[i];
`ifdef LED_STATUS_SYNC_EN
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
`endif
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl with HALF_PERIOD=5 and STRETCH_CYC=4.
// Expected values are hand-derived from the blink period and the event-to-LED latency.
module tb_led_status_ctrl;

`ifdef LED_STATUS_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] mode;
  logic [3:0] evt;
  logic [3:0] led;
  logic       tick;

  int checks;
  int failures;

  led_status_ctrl #(
    .NB_LED      (4),
    .CLK_FREQ_HZ (100),
    .BLINK_HZ    (10),
    .STRETCH_CYC (4)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .mode      (mode),
    .evt       (evt),
    .led       (led),
    .tick      (tick)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive inputs just after an edge, then sample outputs 1 time unit after the next edge.
  task automatic applyStimulus(input logic [7:0] m, input logic [3:0] e);
    mode = m;
    evt  = e;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic runPattern(input string tag, input logic [31:0] pat, input int steps, input int hi_len);
    logic exp0;
    for (int j = 0; j < steps; j++) begin
      applyStimulus(8'h03, {3'b000, pat[j]});
      exp0 = (j >= LAT - 1) && (j < LAT - 1 + hi_len);
      checkOutput(tag, {28'd0, led}, {28'd0, 3'b000, exp0});
    end
  endtask

  task automatic idle(input logic [7:0] m, input int n);
    for (int j = 0; j < n; j++) applyStimulus(m, 4'b0000);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    sys_rst_n = 1'b0;
    mode      = 8'hAA;
    evt       = 4'b0000;

    applyStimulus(8'hAA, 4'b0000);
    applyStimulus(8'hAA, 4'b0000);
    checkOutput("reset_led", {28'd0, led}, 32'd0);
    checkOutput("reset_tick", {31'd0, tick}, 32'd0);

    // Blink on all channels: tick every 5th edge, LEDs flip with it.
    sys_rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      applyStimulus(8'hAA, 4'b0000);
      checkOutput("blink_tick", {31'd0, tick}, {31'd0, (n % 5) == 0});
      checkOutput("blink_led", {28'd0, led}, ((n / 5) % 2 == 1) ? 32'hF : 32'h0);
    end

    idle(8'h03, 3);
    runPattern("stretch_single", 32'h0000_0001, 10, 4);
    idle(8'h03, 4);
    runPattern("stretch_retrigger", 32'h0000_0005, 12, 6);
    idle(8'h03, 4);
    runPattern("stretch_held", 32'h000F_FFFF, 26, 4);
    idle(8'h03, 4);

    // Reset during an active stretch on ch0 and blink on ch1..3.
    applyStimulus(8'hAB, 4'b0001);
    applyStimulus(8'hAB, 4'b0000);
    applyStimulus(8'hAB, 4'b0000);
    checkOutput("pre_reset_stretch", {31'd0, led[0]}, 32'd1);
    sys_rst_n = 1'b0;
    applyStimulus(8'hAB, 4'b0000);
    checkOutput("midrst_led", {28'd0, led}, 32'd0);
    checkOutput("midrst_tick", {31'd0, tick}, 32'd0);
    sys_rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      applyStimulus(8'hAB, 4'b0000);
      checkOutput("postrst_tick", {31'd0, tick}, {31'd0, (n % 5) == 0});
      checkOutput("postrst_led", {28'd0, led}, ((n / 5) % 2 == 1) ? 32'hE : 32'h0);
    end

    // evt already high when reset releases must not light ch0.
    sys_rst_n = 1'b0;
    applyStimulus(8'h03, 4'b0001);
    sys_rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      applyStimulus(8'h03, 4'b0001);
      checkOutput("evt_high_at_release", {28'd0, led}, 32'd0);
    end
    idle(8'h03, 4);

    // Static modes ignore evt entirely; changes land on the very next edge.
    for (int n = 0; n < 12; n++) begin
      applyStimulus(8'h44, 4'($urandom));
      checkOutput("static_44", {28'd0, led}, 32'hA);
    end
    for (int n = 0; n < 12; n++) begin
      applyStimulus(8'h11, 4'($urandom));
      checkOutput("static_11", {28'd0, led}, 32'h5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
